// File: rtl/tag_pkg.sv
// Shared types and sizing for the physical-tag allocation controller.
package tag_pkg;

   localparam int unsigned NUM_TAGS = 128;
   localparam int unsigned TAG_W    = $clog2(NUM_TAGS) + 1;

   typedef logic [TAG_W-1:0] tag_t;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      FLUSH_WAIT
   } alloc_state_e;

endpackage

// File: rtl/tag_return_queue.sv
// Two-in / one-out circular FIFO holding returned tags until they are drained
// into the free list. Pushes are accepted only while two entries are free.
module tag_return_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_0,
   input  logic          push_1,
   input  logic [W-1:0]  data_0,
   input  logic [W-1:0]  data_1,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          ready
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic          acc_0;
   logic          acc_1;
   logic          do_pop;
   logic [CW-1:0] n_push;

   always_comb begin
      ready  = (CW'(DEPTH) - cnt) >= CW'(2);
      acc_0  = push_0 & ready;
      acc_1  = push_1 & ready;
      do_pop = pop & (cnt != '0);
      n_push = CW'(acc_0) + CW'(acc_1);
      head   = mem[rd_ptr];
      count  = cnt;
   end

   // Slot 1 lands behind slot 0 when both push; alone it takes slot 0's place.
   always_ff @(posedge clk) begin
      if (acc_0) mem[wr_ptr] <= data_0;
      if (acc_1) mem[acc_0 ? wr_ptr + AW'(1) : wr_ptr] <= data_1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(n_push);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + n_push - CW'(do_pop);
      end
   end

endmodule

// File: rtl/tag_alloc_ctrl.sv
// Rename-stage tag allocator: all-or-nothing dual grant from the free list,
// return-queue drain, and post-flush allocation block. TAG_ALLOC_STATS_EN adds stall_count.
module tag_alloc_ctrl
   import tag_pkg::*;
#(
   parameter int unsigned NUM_TAGS = tag_pkg::NUM_TAGS,
   parameter int unsigned RQ_DEPTH = 4,
   parameter int unsigned TAG_W    = $clog2(NUM_TAGS) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_0,
   input  logic             req_valid_1,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag_0,
   output logic [TAG_W-1:0] alloc_tag_1,
   input  logic             flush,
   input  logic             ret_valid_0,
   input  logic             ret_valid_1,
   input  logic [TAG_W-1:0] ret_tag_0,
   input  logic [TAG_W-1:0] ret_tag_1,
   output logic             ret_ready,
   output logic             fl_read_1,
   output logic             fl_read_2,
   input  logic [TAG_W-1:0] fl_tag_0,
   input  logic [TAG_W-1:0] fl_tag_1,
   input  logic [TAG_W-1:0] fl_num_items,
   output logic             fl_write_tag,
   output logic [TAG_W-1:0] fl_write_source
`ifdef TAG_ALLOC_STATS_EN
   ,
   output logic [31:0]      stall_count
`endif
);

   localparam int unsigned CW = $clog2(RQ_DEPTH) + 1;

   alloc_state_e     state;
   alloc_state_e     state_nxt;
   logic [1:0]       need;
   logic [CW-1:0]    rq_count;
   logic [TAG_W-1:0] rq_head;
   logic             rq_nonempty;

   tag_return_queue #(
      .DEPTH (RQ_DEPTH),
      .W     (TAG_W)
   ) u_rq (
      .clk    (clk),
      .reset  (reset),
      .push_0 (ret_valid_0),
      .push_1 (ret_valid_1),
      .data_0 (ret_tag_0),
      .data_1 (ret_tag_1),
      .pop    (rq_nonempty),
      .head   (rq_head),
      .count  (rq_count),
      .ready  (ret_ready)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= INIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      need            = {1'b0, req_valid_0} + {1'b0, req_valid_1};
      rq_nonempty     = (rq_count != '0);
      alloc_ready     = 1'b0;
      alloc_tag_0     = '0;
      alloc_tag_1     = '0;
      fl_read_1       = 1'b0;
      fl_read_2       = 1'b0;
      fl_write_tag    = rq_nonempty;
      fl_write_source = rq_nonempty ? rq_head : '0;

      unique case (state)
         INIT:       state_nxt = RUN;
         RUN:        if (flush) state_nxt = FLUSH_WAIT;
         FLUSH_WAIT: if (!flush && !rq_nonempty) state_nxt = RUN;
         default:    state_nxt = INIT;
      endcase

      // Grant only when every requesting slot can be served.
      alloc_ready = (state == RUN) && !flush && (need != 2'd0) &&
                    (fl_num_items >= TAG_W'(need));
      if (alloc_ready) begin
         if (need == 2'd2) begin
            fl_read_2   = 1'b1;
            alloc_tag_0 = fl_tag_0;
            alloc_tag_1 = fl_tag_1;
         end else begin
            fl_read_1 = 1'b1;
            if (req_valid_0) alloc_tag_0 = fl_tag_0;
            else             alloc_tag_1 = fl_tag_0;
         end
      end
   end

`ifdef TAG_ALLOC_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if ((state == RUN) && (need != 2'd0) && !alloc_ready &&
                   (stall_count != '1)) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Scoreboard bench for tag_alloc_ctrl: directed scenarios then random traffic
// against a queue-based reference model.
module tb_tag_alloc_ctrl;
   import tag_pkg::*;

   localparam int unsigned RQ_DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic req_valid_0 = 1'b0, req_valid_1 = 1'b0, flush = 1'b0;
   logic ret_valid_0 = 1'b0, ret_valid_1 = 1'b0;
   tag_t ret_tag_0 = '0, ret_tag_1 = '0;
   tag_t fl_tag_0 = '0, fl_tag_1 = '0, fl_num_items = '0;
   logic alloc_ready, ret_ready, fl_read_1, fl_read_2, fl_write_tag;
   tag_t alloc_tag_0, alloc_tag_1, fl_write_source;
`ifdef TAG_ALLOC_STATS_EN
   logic [31:0] stall_count;
`endif

   tag_alloc_ctrl #(.NUM_TAGS(128), .RQ_DEPTH(RQ_DEPTH)) dut (
      .clk(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .alloc_ready(alloc_ready), .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
      .flush(flush),
      .ret_valid_0(ret_valid_0), .ret_valid_1(ret_valid_1),
      .ret_tag_0(ret_tag_0), .ret_tag_1(ret_tag_1), .ret_ready(ret_ready),
      .fl_read_1(fl_read_1), .fl_read_2(fl_read_2),
      .fl_tag_0(fl_tag_0), .fl_tag_1(fl_tag_1), .fl_num_items(fl_num_items),
      .fl_write_tag(fl_write_tag), .fl_write_source(fl_write_source)
`ifdef TAG_ALLOC_STATS_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rdy;
      int unsigned t0, t1;
      bit          rd1, rd2, wr;
      int unsigned src;
      bit          rr;
      int unsigned stall;
   } exp_t;

   // Reference model: mode 0 = waiting for free-list init, 1 = allocating, 2 = post-flush.
   int          mode = 0;
   int unsigned rq[$];
   int unsigned stall = 0;
   exp_t        cur;
   exp_t        sb[$];
   int unsigned n_cmp = 0, n_bad = 0;

   function automatic exp_t compute_exp();
      exp_t e;
      int unsigned need = int'(req_valid_0) + int'(req_valid_1);
      e.rdy = (mode == 1) && !flush && need != 0 && int'(fl_num_items) >= need;
      e.t0  = (e.rdy && req_valid_0) ? int'(fl_tag_0) : 0;
      e.t1  = !e.rdy ? 0 : (need == 2) ? int'(fl_tag_1) : (req_valid_1 ? int'(fl_tag_0) : 0);
      e.rd1 = e.rdy && need == 1;
      e.rd2 = e.rdy && need == 2;
      e.wr  = rq.size() > 0;
      e.src = e.wr ? rq[0] : 0;
      e.rr  = (RQ_DEPTH - rq.size()) >= 2;
      e.stall = stall;
      return e;
   endfunction

   task automatic step(input bit rst, input bit f, input bit q0, input bit q1,
                       input bit v0, input bit v1, input int unsigned a0, input int unsigned a1,
                       input int unsigned num, input int unsigned ft0, input int unsigned ft1);
      bit hold;
      @(posedge clk);
      if (reset) begin
         int unsigned sz = rq.size();
         if (cur.wr) void'(rq.pop_front());
         if (cur.rr) begin
            if (ret_valid_0) rq.push_back(int'(ret_tag_0));
            if (ret_valid_1) rq.push_back(int'(ret_tag_1));
         end
         if (mode == 1 && (req_valid_0 || req_valid_1) && !cur.rdy) stall++;
         case (mode)
            0: mode = 1;
            1: if (flush) mode = 2;
            default: if (!flush && sz == 0) mode = 1;
         endcase
      end
      // A producer refused last cycle must keep presenting the same returns.
      hold = reset && (ret_valid_0 || ret_valid_1) && !cur.rr;
      #1;
      reset = rst; flush = f; req_valid_0 = q0; req_valid_1 = q1;
      if (!hold) begin
         ret_valid_0 = v0; ret_valid_1 = v1;
         ret_tag_0 = tag_t'(a0); ret_tag_1 = tag_t'(a1);
      end
      fl_num_items = tag_t'(num); fl_tag_0 = tag_t'(ft0); fl_tag_1 = tag_t'(ft1);
      if (!reset) begin
         mode = 0; rq.delete(); stall = 0;
      end
      cur = compute_exp();
      sb.push_back(cur);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 64, 3, 4);
   endtask

   function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("alloc_ready", int'(alloc_ready), int'(e.rdy));
            chk("alloc_tag_0", int'(alloc_tag_0), e.t0);
            chk("alloc_tag_1", int'(alloc_tag_1), e.t1);
            chk("fl_read_1", int'(fl_read_1), int'(e.rd1));
            chk("fl_read_2", int'(fl_read_2), int'(e.rd2));
            chk("fl_write_tag", int'(fl_write_tag), int'(e.wr));
            chk("fl_write_source", int'(fl_write_source), e.src);
            chk("ret_ready", int'(ret_ready), int'(e.rr));
`ifdef TAG_ALLOC_STATS_EN
            chk("stall_count", stall_count, e.stall);
`endif
         end
      end
   end

   initial begin : stimulus
      cur = compute_exp();
      step(0, 0, 1, 1, 0, 0, 0, 0, 127, 0, 1);
      step(0, 0, 1, 1, 0, 0, 0, 0, 127, 0, 1);
      // Release: one INIT cycle with no grant, then a dual grant of tags 0 and 1.
      step(1, 0, 1, 1, 0, 0, 0, 0, 127, 0, 1);
      step(1, 0, 1, 1, 0, 0, 0, 0, 127, 0, 1);
      // One free tag cannot satisfy two slots; slot 1 alone takes it.
      step(1, 0, 1, 1, 0, 0, 0, 0, 1, 7, 8);
      step(1, 0, 0, 1, 0, 0, 0, 0, 1, 7, 8);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 7, 8);
      step(1, 0, 1, 0, 0, 0, 0, 0, 2, 11, 12);
      // Returns 5 then 9 drain on consecutive cycles.
      step(1, 0, 0, 0, 1, 1, 5, 9, 64, 3, 4);
      idle(3);
      // Saturate the return queue; refused pairs are held and later accepted.
      for (int unsigned i = 0; i < 4; i++)
         step(1, 0, 0, 0, 1, 1, 20 + 2 * i, 21 + 2 * i, 64, 3, 4);
      idle(8);
      // Flush with three tags queued blocks grants until drained and flush drops.
      step(1, 0, 0, 0, 1, 1, 30, 31, 64, 3, 4);
      step(1, 0, 0, 0, 1, 1, 32, 33, 64, 3, 4);
      step(1, 1, 1, 1, 0, 0, 0, 0, 100, 50, 51);
      for (int unsigned i = 0; i < 6; i++) step(1, 0, 1, 1, 0, 0, 0, 0, 100, 50 + i, 60 + i);
      // Reset mid-drain discards queued tags.
      step(1, 0, 0, 0, 1, 1, 40, 41, 64, 3, 4);
      step(1, 0, 0, 0, 1, 1, 42, 43, 64, 3, 4);
      step(0, 0, 0, 0, 0, 0, 0, 0, 64, 3, 4);
      step(0, 0, 0, 0, 0, 0, 0, 0, 64, 3, 4);
      step(1, 0, 0, 0, 0, 0, 0, 0, 64, 3, 4);
      idle(3);
      for (int unsigned i = 0; i < 3000; i++) begin
         int unsigned num;
         num = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 128);
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 127), $urandom_range(0, 127),
              num, $urandom_range(0, 127), $urandom_range(0, 127));
      end
      idle(2);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tag_alloc_ctrl.md
# tag_alloc_ctrl

Sequencer between the rename stage and the physical-tag free list. Grants up to two destination tags per cycle to the two decode slots, all-or-nothing and in order. Collects up to two retiring or squashed tags per cycle into a small return queue and drains it into the free list one tag per cycle. Blocks allocation after a pipeline flush until every returned tag is back in the free list.

## Interface
Parameters:
- NUM_TAGS, 128, number of physical tags; must match the free list's WIDTH.
- RQ_DEPTH, 4, return-queue entries; power of two, at least 2.
- TAG_W, $clog2(NUM_TAGS)+1, tag and count width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- req_valid_0 / req_valid_1  in  1  decode slot 0/1 holds an instruction needing a destination tag.
- alloc_ready  out  1  requests granted this cycle; decode advances on alloc_ready.
- alloc_tag_0 / alloc_tag_1  out  TAG_W  tag for slot 0/1; valid only when alloc_ready is high and the slot is requesting.
- flush  in  1  pipeline flush.
- ret_valid_0 / ret_valid_1  in  1  tag returned (retire or squash).
- ret_tag_0 / ret_tag_1  in  TAG_W  returned tag values.
- ret_ready  out  1  queue can accept two tags this cycle.
- fl_read_1 / fl_read_2  out  1  pop one or two tags from the free list; never both high.
- fl_tag_0 / fl_tag_1  in  TAG_W  free-list head and head+1.
- fl_num_items  in  TAG_W  tags held in the free list.
- fl_write_tag  out  1  push one tag into the free list.
- fl_write_source  out  TAG_W  tag being pushed.
- stall_count  out  32  cycles with a request pending but alloc_ready low; present only under TAG_ALLOC_STATS_EN.

## Operation
- FSM states: INIT, RUN, FLUSH_WAIT.
  - reset low: go to INIT.
  - INIT -> RUN after one clock with reset high. This gives the free list one cycle to initialise.
  - RUN -> FLUSH_WAIT when flush is high.
  - FLUSH_WAIT -> RUN when flush is low and the return queue is empty.
- Tag demand need = req_valid_0 + req_valid_1, range 0..2.
- alloc_ready = (state == RUN) & !flush & (need != 0) & (fl_num_items >= need). The compare is unsigned at TAG_W bits.
- Grant routing:
  - need == 2: fl_read_2 is asserted; alloc_tag_0 = fl_tag_0 and alloc_tag_1 = fl_tag_1.
  - need == 1: fl_read_1 is asserted; fl_tag_0 goes to whichever slot is requesting.
  - The other alloc_tag output is driven to 0.
- A grant is never partial. If two tags are needed and only one is free, neither slot is granted.
- Return queue:
  - Circular FIFO of RQ_DEPTH entries.
  - ret_ready = (free entries >= 2).
  - When ret_ready is high, the cycle's valid returns are pushed, slot 0 first.
  - Returns presented while ret_ready is low are ignored; the producer must hold them.
- Drain:
  - Whenever the queue is non-empty, fl_write_tag = 1 and fl_write_source = the queue head. The head is popped at the same edge.
  - A push and a pop in the same cycle are legal; occupancy changes by pushes − 1.
- Read and write pointers wrap modulo RQ_DEPTH. Occupancy uses a count register of $clog2(RQ_DEPTH)+1 bits.
- flush does not clear the return queue. Squashed tags arrive through the ret_* ports.

## Timing
- Allocation is combinational from fl_num_items and fl_tag_*. Tags are usable in the grant cycle, and the free-list pointer advances at the next edge.
- Return-to-free-list latency:
  - A tag pushed at edge N appears on fl_write_source in cycle N+1.
  - It is counted in fl_num_items from cycle N+2.
  - There is no same-cycle bypass into allocation.
- Reset values:
  - state = INIT; queue empty.
  - alloc_ready = 0, fl_read_1 = 0, fl_read_2 = 0, fl_write_tag = 0.
  - ret_ready = 1; all tag outputs = 0; stall_count = 0.
- Reset asserted mid-operation: queued tags are discarded and all outputs return to their reset values at once.
- Flush and request in the same cycle: the flush wins and no grant is made.

## Configuration
- TAG_ALLOC_STATS_EN defined:
  - stall_count exists.
  - It increments in each RUN cycle where need != 0 and alloc_ready is low.
  - It saturates at 2^32−1 and is cleared by reset.
- TAG_ALLOC_STATS_EN undefined: the port and its counter are absent. No other behaviour changes.

## Structure
- Package tag_pkg holds:
  - NUM_TAGS and TAG_W;
  - typedef tag_t of logic [TAG_W-1:0];
  - enum alloc_state_e with INIT, RUN, FLUSH_WAIT.
- Sub-module tag_return_queue: a 2-in/1-out FIFO with push_0/push_1, data, pop, head, count and ready. The top level holds the FSM, grant logic and counter.

## Test plan
- Reset release with fl_num_items = 127 and both slots requesting: alloc_ready is 0 for one cycle (INIT). Then alloc_ready = 1, alloc_tag_0 = 0, alloc_tag_1 = 1 and fl_read_2 = 1.
- fl_num_items = 1 with both slots requesting: alloc_ready = 0 and no fl_read_*. Next, drop req_valid_0 with req_valid_1 still high: alloc_tag_1 = fl_tag_0 and fl_read_1 = 1.
- Push tags 5 and 9 in one cycle: fl_write_source = 5 in the next cycle and 9 in the cycle after. fl_write_tag then falls.
- Push two tags every cycle for 4 cycles: ret_ready falls once occupancy exceeds 2. Held returns are accepted after the drain, with no tag lost or duplicated.
- Flush with 3 tags queued: alloc_ready = 0 until the queue empties and flush is low, then it resumes in RUN.
- Reset low mid-drain: fl_write_tag goes to 0 immediately, and the queue is empty after release.
